mem_dcache_ctrl: RTL and testbench

//  Sequences the MEM-stage data-cache access for one load/store at a time, between EX_MEM and MEM_WB.

---
 rtl/mem_dcache_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_dcache_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dcache_ctrl.sv
// MEM-stage data-cache sequencer: one load/store at a time, stalls upstream and
// bubbles MEM_WB until the DCache completes, drains orphaned accesses on flush.
module mem_dcache_ctrl #(
    parameter int WORD    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_is_load,
    input  logic            mem_is_store,
    input  logic [WORD-1:0] mem_addr,
    input  logic [WORD-1:0] mem_wdata,
    input  logic [3:0]      mem_wstrb,
    input  logic            pipe_flush,
    output logic            dc_req,
    output logic            dc_we,
    output logic [WORD-1:0] dc_addr,
    output logic [WORD-1:0] dc_wdata,
    output logic [3:0]      dc_wstrb,
    input  logic            dc_addr_ok,
    input  logic            dc_data_ok,
    input  logic [WORD-1:0] dc_rdata,
    output logic            pipe_stall,
    output logic            mem_wb_flush,
    output logic [WORD-1:0] ld_data,
    output logic            ld_valid,
    output logic            err,
    output logic [2:0]      dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [WORD-1:0] ld_data_q, ld_data_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q, we_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            new_req;
    logic            busy;

    assign new_req = mem_valid & (mem_is_load | mem_is_store) & ~pipe_flush;
    assign busy    = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            ld_data_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            ld_data_q <= ld_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Handshake: dc_req is held with dc_addr/dc_wdata/dc_wstrb/dc_we stable until the
    // cycle dc_addr_ok is seen; the response is the single-cycle dc_data_ok pulse after
    // (or together with) acceptance. dc_data_ok before acceptance is ignored.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = we_q;
        ld_data_d  = ld_data_q;
        dc_req     = 1'b0;
        pipe_stall = 1'b0;
        ld_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (new_req) begin
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_wstrb;
                    we_d       = mem_is_store;
                    pipe_stall = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                dc_req     = 1'b1;
                pipe_stall = 1'b1;
                if (dc_addr_ok) begin
                    if (pipe_flush) begin
                        state_d = dc_data_ok ? IDLE : DRAIN;
                    end else if (dc_data_ok) begin
                        if (!we_q) ld_data_d = dc_rdata;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (pipe_flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                pipe_stall = 1'b1;
                if (pipe_flush) begin
                    state_d = dc_data_ok ? IDLE : DRAIN;
                end else if (dc_data_ok) begin
                    if (!we_q) ld_data_d = dc_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                ld_valid = ~pipe_flush;
                state_d  = IDLE;
            end
            DRAIN: begin
                pipe_stall = 1'b1;
                if (dc_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-access watchdog; saturates so err stays meaningful on very long hangs.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (busy) begin
            cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
        end
    end

    assign dc_we        = we_q;
    assign dc_addr      = addr_q;
    assign dc_wdata     = wdata_q;
    assign dc_wstrb     = wstrb_q;
    assign ld_data      = ld_data_q;
    assign err          = err_q;
    assign mem_wb_flush = pipe_stall;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// Directed bench for mem_dcache_ctrl: completions are scored against an expected queue
// by a negedge monitor; cycle-level stall/handshake checks sit in the stimulus.
module tb_mem_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_is_load, mem_is_store;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        pipe_flush;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        pipe_stall, mem_wb_flush;
  logic [31:0] ld_data;
  logic        ld_valid, err;
  logic [2:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int stalls;

  mem_dcache_ctrl #(.WORD(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .pipe_flush(pipe_flush),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok),
    .dc_rdata(dc_rdata), .pipe_stall(pipe_stall), .mem_wb_flush(mem_wb_flush),
    .ld_data(ld_data), .ld_valid(ld_valid), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("flush_eq_stall", {31'b0, mem_wb_flush}, {31'b0, pipe_stall});
      if (ld_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ld_valid: got ld_valid=1 with ld_data 0x%08h, expected no completion", ld_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("sb_ld_data", ld_data, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic is_store, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_valid    = 1'b1;
    mem_is_load  = ~is_store;
    mem_is_store = is_store;
    mem_addr     = addr;
    mem_wdata    = wdata;
    mem_wstrb    = wstrb;
  endtask

  task automatic clear_mem();
    mem_valid    = 1'b0;
    mem_is_load  = 1'b0;
    mem_is_store = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ctl"}, {26'b0, dc_req, dc_we, pipe_stall, mem_wb_flush, ld_valid, err}, 32'h0);
    check({tag, "_addr"}, dc_addr, 32'h0);
    check({tag, "_wdata"}, dc_wdata, 32'h0);
    check({tag, "_wstrb"}, {28'b0, dc_wstrb}, 32'h0);
    check({tag, "_ld_data"}, ld_data, 32'h0);
    check({tag, "_state"}, {29'b0, dbg_state}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    clear_mem();
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    pipe_flush = 1'b0;
    dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = '0;
    #3;
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: load, addr_ok in first REQ cycle, data_ok 2 cycles later
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    settle();
    check("t1_stall_idle_new", {31'b0, pipe_stall}, 32'd1);
    stalls = int'(pipe_stall);
    tick();
    clear_mem();
    dc_addr_ok = 1'b1;
    settle();
    check("t1_req", {31'b0, dc_req}, 32'd1);
    check("t1_we", {31'b0, dc_we}, 32'd0);
    check("t1_addr", dc_addr, 32'h0000_0040);
    stalls += int'(pipe_stall);
    tick();
    dc_addr_ok = 1'b0;
    settle();
    check("t1_wait_no_req", {31'b0, dc_req}, 32'd0);
    stalls += int'(pipe_stall);
    tick();
    dc_data_ok = 1'b1;
    dc_rdata   = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    stalls += int'(pipe_stall);
    tick();
    dc_data_ok = 1'b0;
    dc_rdata   = 32'h0;
    settle();
    check("t1_done_valid", {31'b0, ld_valid}, 32'd1);
    check("t1_done_nostall", {31'b0, pipe_stall}, 32'd0);
    check("t1_stall_cycles", stalls, 32'd4);
    tick();
    settle();
    check("t1_valid_one_cycle", {31'b0, ld_valid}, 32'd0);

    // 2: store, addr_ok+data_ok in the first REQ cycle
    tick();
    issue(1'b1, 32'h0000_1000, 32'h1234_5678, 4'h3);
    tick();
    clear_mem();
    dc_addr_ok = 1'b1;
    dc_data_ok = 1'b1;
    dc_rdata   = 32'hFFFF_FFFF;
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    check("t2_req", {31'b0, dc_req}, 32'd1);
    check("t2_we", {31'b0, dc_we}, 32'd1);
    check("t2_addr", dc_addr, 32'h0000_1000);
    check("t2_wdata", dc_wdata, 32'h1234_5678);
    check("t2_wstrb", {28'b0, dc_wstrb}, 32'h3);
    tick();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b0;
    settle();
    check("t2_done_valid", {31'b0, ld_valid}, 32'd1);
    check("t2_ld_data_kept", ld_data, 32'hDEAD_BEEF);
    tick();

    // 3: load with addr_ok held low for 5 cycles
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    tick();
    clear_mem();
    mem_addr = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t3_req_held", {31'b0, dc_req}, 32'd1);
      check("t3_addr_held", dc_addr, 32'h0000_2000);
      tick();
    end
    dc_addr_ok = 1'b1;
    dc_data_ok = 1'b1;
    dc_rdata   = 32'hCAFE_0003;
    exp_q.push_back(32'hCAFE_0003);
    tick();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b0;
    settle();
    check("t3_done_valid", {31'b0, ld_valid}, 32'd1);
    check("t3_no_err", {31'b0, err}, 32'd0);
    tick();

    // 4: flush in WAIT, data_ok 3 cycles later
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    tick();
    clear_mem();
    dc_addr_ok = 1'b1;
    tick();
    dc_addr_ok = 1'b0;
    pipe_flush = 1'b1;
    settle();
    check("t4_wait_stall", {31'b0, pipe_stall}, 32'd1);
    tick();
    pipe_flush = 1'b0;
    settle();
    check("t4_drain_state", {29'b0, dbg_state}, 32'd4);
    check("t4_drain_stall", {31'b0, pipe_stall}, 32'd1);
    tick();
    settle();
    check("t4_drain_stall2", {31'b0, pipe_stall}, 32'd1);
    tick();
    dc_data_ok = 1'b1;
    dc_rdata   = 32'hBAD0_BAD0;
    settle();
    check("t4_drain_stall3", {31'b0, pipe_stall}, 32'd1);
    tick();
    dc_data_ok = 1'b0;
    settle();
    check("t4_idle_state", {29'b0, dbg_state}, 32'd0);
    check("t4_idle_nostall", {31'b0, pipe_stall}, 32'd0);
    check("t4_ld_data_kept", ld_data, 32'hCAFE_0003);
    tick();

    // 5: no addr_ok for 10 cycles with TIMEOUT=8
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t5_err_rise", {31'b0, err}, (i >= 8) ? 32'd1 : 32'd0);
      tick();
    end
    dc_addr_ok = 1'b1;
    dc_data_ok = 1'b1;
    dc_rdata   = 32'h55AA_55AA;
    exp_q.push_back(32'h55AA_55AA);
    tick();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b0;
    settle();
    check("t5_done_valid", {31'b0, ld_valid}, 32'd1);
    tick();
    settle();
    check("t5_err_sticky", {31'b0, err}, 32'd1);

    // 6: reset mid-WAIT, then a normal load
    tick();
    issue(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    clear_mem();
    dc_addr_ok = 1'b1;
    tick();
    dc_addr_ok = 1'b0;
    settle();
    rst = 1'b0;
    #1;
    check_all_zero("t6_async_rst");
    tick();
    rst = 1'b1;
    tick();
    issue(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    tick();
    clear_mem();
    dc_addr_ok = 1'b1;
    dc_data_ok = 1'b1;
    dc_rdata   = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    settle();
    check("t6_addr", dc_addr, 32'h0000_6000);
    tick();
    dc_addr_ok = 1'b0;
    dc_data_ok = 1'b0;
    settle();
    check("t6_done_valid", {31'b0, ld_valid}, 32'd1);
    check("t6_err_cleared", {31'b0, err}, 32'd0);
    tick();
    tick();

    // report
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
